// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the SRAM-like arbiter: the CPU data word plus the FSM state and owner enums.
package cpu_core_params;
    typedef logic [31:0] cpu_data_t;
endpackage

package sram_like_arbiter_params;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;
endpackage

// File: rtl/sram_like_arbiter_grant.sv
// Combinational grant selection between the instruction and data requesters.
// SRAM_LIKE_ARBITER_ROUND_ROBIN_EN: when both request, the one not served last wins; otherwise data wins.
module sram_like_arbiter_grant
    import sram_like_arbiter_params::*;
(
    input  logic   inst_req,
    input  logic   data_req,
    input  owner_t last_served,
    output owner_t grant
);

`ifndef SRAM_LIKE_ARBITER_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = (last_served == OWN_DATA);
`endif

    always_comb begin
        grant = OWN_INST;
        if (data_req && !inst_req) begin
            grant = OWN_DATA;
        end else if (data_req && inst_req) begin
`ifdef SRAM_LIKE_ARBITER_ROUND_ROBIN_EN
            grant = (last_served == OWN_DATA) ? OWN_INST : OWN_DATA;
`else
            grant = OWN_DATA;
`endif
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave port between instruction and data requesters, one transaction in flight.
// SRAM_LIKE_ARBITER_ROUND_ROBIN_EN selects round-robin instead of fixed data priority.
module sram_like_arbiter
    import cpu_core_params::*;
    import sram_like_arbiter_params::*;
(
    input  logic       clock,
    input  logic       reset_,

    input  logic       instruction_ram_request,
    input  logic       instruction_ram_write,
    input  logic [1:0] instruction_ram_size,
    input  cpu_data_t  instruction_ram_address,
    input  cpu_data_t  instruction_ram_write_data,
    input  logic [3:0] instruction_ram_write_strobe,
    output cpu_data_t  instruction_ram_read_data,
    output logic       instruction_ram_address_ready,
    output logic       instruction_ram_data_ready,

    input  logic       data_ram_request,
    input  logic       data_ram_write,
    input  logic [1:0] data_ram_size,
    input  cpu_data_t  data_ram_address,
    input  cpu_data_t  data_ram_write_data,
    input  logic [3:0] data_ram_write_strobe,
    output cpu_data_t  data_ram_read_data,
    output logic       data_ram_address_ready,
    output logic       data_ram_data_ready,

    output logic       memory_request,
    output logic       memory_write,
    output logic [1:0] memory_size,
    output cpu_data_t  memory_address,
    output cpu_data_t  memory_write_data,
    output logic [3:0] memory_write_strobe,
    input  cpu_data_t  memory_read_data,
    input  logic       memory_address_ready,
    input  logic       memory_data_ready
);

    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    owner_t last_q;
    owner_t grant;
    owner_t sel;
    logic   sel_req;
    logic   req_int;
    logic   data_done;

`ifdef SRAM_LIKE_ARBITER_ROUND_ROBIN_EN
    owner_t last_d;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) last_q <= OWN_INST;
        else         last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (data_done) last_d = owner_q;
    end
`else
    assign last_q = OWN_INST;
`endif

    sram_like_arbiter_grant u_grant (
        .inst_req    (instruction_ram_request),
        .data_req    (data_ram_request),
        .last_served (last_q),
        .grant       (grant)
    );

    // In IDLE the fresh grant steers the port; afterwards the registered owner holds it.
    assign sel       = (state_q == ST_IDLE) ? grant : owner_q;
    assign sel_req   = (sel == OWN_DATA) ? data_ram_request : instruction_ram_request;
    assign req_int   = reset_ && (state_q != ST_DATA) && sel_req;
    assign data_done = (state_q == ST_DATA) && memory_data_ready;

    always_comb begin
        memory_request      = req_int;
        memory_write        = instruction_ram_write;
        memory_size         = instruction_ram_size;
        memory_address      = instruction_ram_address;
        memory_write_data   = instruction_ram_write_data;
        memory_write_strobe = instruction_ram_write_strobe;
        if (sel == OWN_DATA) begin
            memory_write        = data_ram_write;
            memory_size         = data_ram_size;
            memory_address      = data_ram_address;
            memory_write_data   = data_ram_write_data;
            memory_write_strobe = data_ram_write_strobe;
        end
    end

    assign instruction_ram_address_ready = req_int && memory_address_ready && (sel == OWN_INST);
    assign data_ram_address_ready        = req_int && memory_address_ready && (sel == OWN_DATA);
    assign instruction_ram_data_ready    = reset_ && data_done && (owner_q == OWN_INST);
    assign data_ram_data_ready           = reset_ && data_done && (owner_q == OWN_DATA);
    assign instruction_ram_read_data     = memory_read_data;
    assign data_ram_read_data            = memory_read_data;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (instruction_ram_request || data_ram_request) begin
                    owner_d = grant;
                    state_d = memory_address_ready ? ST_DATA : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!sel_req)                  state_d = ST_IDLE;
                else if (memory_address_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (memory_data_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_INST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter; honours SRAM_LIKE_ARBITER_ROUND_ROBIN_EN.
module tb_sram_like_arbiter;
    logic        clock = 1'b0;
    logic        reset_;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size, m_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [3:0]  i_strb, d_strb, m_strb;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic        i_ardy, i_drdy, d_ardy, d_drdy;
    logic        m_req, m_wr, m_ardy, m_drdy;
    int          tests = 0;
    int          fails = 0;

    always #5 clock = ~clock;

    sram_like_arbiter dut (
        .clock(clock), .reset_(reset_),
        .instruction_ram_request(i_req), .instruction_ram_write(i_wr),
        .instruction_ram_size(i_size), .instruction_ram_address(i_addr),
        .instruction_ram_write_data(i_wdata), .instruction_ram_write_strobe(i_strb),
        .instruction_ram_read_data(i_rdata), .instruction_ram_address_ready(i_ardy),
        .instruction_ram_data_ready(i_drdy),
        .data_ram_request(d_req), .data_ram_write(d_wr),
        .data_ram_size(d_size), .data_ram_address(d_addr),
        .data_ram_write_data(d_wdata), .data_ram_write_strobe(d_strb),
        .data_ram_read_data(d_rdata), .data_ram_address_ready(d_ardy),
        .data_ram_data_ready(d_drdy),
        .memory_request(m_req), .memory_write(m_wr), .memory_size(m_size),
        .memory_address(m_addr), .memory_write_data(m_wdata),
        .memory_write_strobe(m_strb), .memory_read_data(m_rdata),
        .memory_address_ready(m_ardy), .memory_data_ready(m_drdy)
    );

    task automatic quiet();
        i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = 32'hBFC00000; i_wdata = 0; i_strb = 0;
        d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = 32'h80000000; d_wdata = 0; d_strb = 0;
        m_ardy = 0; m_drdy = 0; m_rdata = 0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 time units later.
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        quiet();
        reset_ = 0;
        i_req = 1; d_req = 1; m_ardy = 1; m_drdy = 1;
        tick(); settle();
        tests++;
        if ({m_req, i_ardy, d_ardy, i_drdy, d_drdy} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 00000", {m_req, i_ardy, d_ardy, i_drdy, d_drdy});
        end
        tick(); quiet(); reset_ = 1;
        tick(); settle();
        tests++;
        if (m_req !== 1'b0) begin fails++; $display("FAIL idle_no_req: m_req=%b want 0", m_req); end
    endtask

    task automatic test_inst_read();
        tick(); quiet();
        i_req = 1; i_addr = 32'hBFC00000; m_ardy = 1; settle();
        tests++;
        if (m_req !== 1 || m_addr !== 32'hBFC00000 || m_wr !== 0 || i_ardy !== 1 || d_ardy !== 0) begin
            fails++;
            $display("FAIL inst_issue: req=%b addr=%h wr=%b iardy=%b dardy=%b want 1 bfc00000 0 1 0",
                     m_req, m_addr, m_wr, i_ardy, d_ardy);
        end
        tick(); i_req = 0; m_ardy = 0; settle();
        tests++;
        if (m_req !== 0 || i_drdy !== 0) begin
            fails++; $display("FAIL inst_wait: req=%b idrdy=%b want 0 0", m_req, i_drdy);
        end
        tick(); m_drdy = 1; m_rdata = 32'h3C1D0001; settle();
        tests++;
        if (i_drdy !== 1 || d_drdy !== 0 || i_rdata !== 32'h3C1D0001 || d_rdata !== 32'h3C1D0001) begin
            fails++;
            $display("FAIL inst_data: idrdy=%b ddrdy=%b ird=%h drd=%h want 1 0 3c1d0001 3c1d0001",
                     i_drdy, d_drdy, i_rdata, d_rdata);
        end
        tick(); m_drdy = 0; settle();
        tests++;
        if (i_drdy !== 0 || m_req !== 0) begin
            fails++; $display("FAIL inst_single_pulse: idrdy=%b req=%b want 0 0", i_drdy, m_req);
        end
    endtask

    task automatic test_priority();
        tick(); quiet();
        i_req = 1; i_addr = 32'hBFC00004;
        d_req = 1; d_wr = 1; d_addr = 32'h80000010; d_strb = 4'hF; d_wdata = 32'h12345678;
        m_ardy = 1; settle();
        tests++;
        if (m_addr !== 32'h80000010 || m_wr !== 1 || m_strb !== 4'hF || m_wdata !== 32'h12345678
            || d_ardy !== 1 || i_ardy !== 0) begin
            fails++;
            $display("FAIL prio_data_wins: addr=%h wr=%b strb=%h wd=%h dardy=%b iardy=%b",
                     m_addr, m_wr, m_strb, m_wdata, d_ardy, i_ardy);
        end
        tick(); d_req = 0; d_wr = 0; m_ardy = 0; m_drdy = 1; settle();
        tests++;
        if (d_drdy !== 1 || i_drdy !== 0 || m_req !== 0) begin
            fails++; $display("FAIL prio_data_done: ddrdy=%b idrdy=%b req=%b want 1 0 0", d_drdy, i_drdy, m_req);
        end
        tick(); m_drdy = 0; m_ardy = 1; settle();
        tests++;
        if (m_req !== 1 || m_addr !== 32'hBFC00004 || i_ardy !== 1 || d_ardy !== 0) begin
            fails++; $display("FAIL prio_inst_next: req=%b addr=%h iardy=%b want 1 bfc00004 1", m_req, m_addr, i_ardy);
        end
        tick(); i_req = 0; m_ardy = 0; m_drdy = 1;
        tick(); quiet();
    endtask

    task automatic test_lock();
        tick(); quiet();
        i_req = 1; i_addr = 32'hBFC00100; settle();
        tick(); d_req = 1; d_addr = 32'h80000200;
        for (int c = 0; c < 3; c++) begin
            settle();
            tests++;
            if (m_addr !== 32'hBFC00100 || m_req !== 1 || d_ardy !== 0) begin
                fails++; $display("FAIL lock_cycle%0d: addr=%h req=%b dardy=%b want bfc00100 1 0", c, m_addr, m_req, d_ardy);
            end
            tick();
        end
        m_ardy = 1; settle();
        tests++;
        if (i_ardy !== 1 || d_ardy !== 0) begin
            fails++; $display("FAIL lock_accept: iardy=%b dardy=%b want 1 0", i_ardy, d_ardy);
        end
        tick(); i_req = 0; d_req = 0; m_ardy = 0; m_drdy = 1;
        tick(); quiet();
    endtask

    task automatic test_round_robin();
        logic exp_data [4];
        tick(); quiet(); reset_ = 0;
        tick(); reset_ = 1;
`ifdef SRAM_LIKE_ARBITER_ROUND_ROBIN_EN
        exp_data = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_data = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        i_req = 1; i_addr = 32'hBFC00008; d_req = 1; d_addr = 32'h80000020;
        for (int t = 0; t < 4; t++) begin
            tick(); m_drdy = 0; m_ardy = 1; settle();
            tests++;
            if (m_addr !== (exp_data[t] ? 32'h80000020 : 32'hBFC00008) || d_ardy !== exp_data[t]
                || i_ardy !== !exp_data[t]) begin
                fails++;
                $display("FAIL grant_order%0d: addr=%h dardy=%b iardy=%b want data=%b", t, m_addr, d_ardy, i_ardy, exp_data[t]);
            end
            tick(); m_ardy = 0; m_drdy = 1;
        end
        tick(); quiet();
    endtask

    task automatic test_reset_mid();
        tick(); quiet();
        i_req = 1; m_ardy = 1;
        tick(); i_req = 0; m_ardy = 0;
        #1 reset_ = 0; #1;
        tests++;
        if ({m_req, i_drdy, d_drdy, i_ardy, d_ardy} !== 5'b0) begin
            fails++; $display("FAIL reset_mid_outputs: got %b want 00000", {m_req, i_drdy, d_drdy, i_ardy, d_ardy});
        end
        tick(); reset_ = 1;
        tick(); m_drdy = 1; settle();
        tests++;
        if (i_drdy !== 0 || d_drdy !== 0 || m_req !== 0) begin
            fails++; $display("FAIL reset_stale_drdy: idrdy=%b ddrdy=%b req=%b want 0 0 0", i_drdy, d_drdy, m_req);
        end
        tick(); quiet();
    endtask

    task automatic test_drop();
        tick(); quiet();
        d_req = 1; d_addr = 32'h80000040; settle();
        tick(); d_req = 0; m_ardy = 1; settle();
        tests++;
        if (m_req !== 0 || d_ardy !== 0 || i_ardy !== 0) begin
            fails++; $display("FAIL drop_addr: req=%b dardy=%b iardy=%b want 0 0 0", m_req, d_ardy, i_ardy);
        end
        tick(); m_ardy = 0; m_drdy = 1; settle();
        tests++;
        if (d_drdy !== 0 || i_drdy !== 0) begin
            fails++; $display("FAIL drop_no_drdy: ddrdy=%b idrdy=%b want 0 0", d_drdy, i_drdy);
        end
        tick(); m_drdy = 0; i_req = 1; i_addr = 32'hBFC00010; m_ardy = 1; settle();
        tests++;
        if (m_req !== 1 || m_addr !== 32'hBFC00010 || i_ardy !== 1) begin
            fails++; $display("FAIL drop_back_idle: req=%b addr=%h iardy=%b want 1 bfc00010 1", m_req, m_addr, i_ardy);
        end
        tick(); quiet();
    endtask

    initial begin
        quiet();
        reset_ = 0;
        test_reset();
        test_inst_read();
        test_priority();
        test_lock();
        test_round_robin();
        test_reset_mid();
        test_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have no parameters; data width is 32 bits via cpu_core_params::cpu_data_t.
REQ-002 SHALL have port: clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset_  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: instruction_ram_request/write  input  1 each; instruction_ram_size  input  2; instruction_ram_address/write_data  input  32; instruction_ram_write_strobe  input  4.
REQ-005 SHALL have ports: instruction_ram_read_data  output  32; instruction_ram_address_ready/data_ready  output  1 each.
REQ-006 SHALL have ports: data_ram_* with the same names, directions and widths as REQ-004/005, data-side requester.
REQ-007 SHALL have ports: memory_request/write  output  1; memory_size  output  2; memory_address/write_data  output  32; memory_write_strobe  output  4.
REQ-008 SHALL have ports: memory_read_data  input  32; memory_address_ready/data_ready  input  1 each (shared downstream slave).

Function
REQ-009 SHALL share the one downstream SRAM-like port between the instruction and data requesters, with at most one transaction outstanding.
REQ-010 SHALL implement FSM IDLE, ADDR, DATA with a registered owner (INST/DATA).
REQ-011 IDLE, no request: memory_request=0; state stays IDLE.
REQ-012 IDLE, any request: SHALL pick grantee combinationally (REQ-020/021) and drive its request/write/size/address/write_data/write_strobe onto memory_* that same cycle (zero-cycle latency).
REQ-013 IDLE: on memory_address_ready with the grant, owner<=grantee and next state DATA; otherwise owner<=grantee and next state ADDR.
REQ-014 ADDR: SHALL drive only the owner's signals; grant is locked and the other requester cannot pre-empt.
REQ-015 ADDR: on memory_address_ready, SHALL go to DATA; if owner's request drops before acceptance, SHALL go to IDLE with no transaction.
REQ-016 DATA: memory_request=0; on memory_data_ready, SHALL pulse owner's data_ready the same cycle and go to IDLE.
REQ-017 SHALL route memory_address_ready and memory_data_ready only to the granted/owning requester; the other requester sees 0.
REQ-018 SHALL broadcast memory_read_data to both read_data outputs unchanged.
REQ-019 A transaction leaving DATA SHALL enable a new grant no earlier than the following cycle (one IDLE cycle minimum).
REQ-020 Default arbitration: with simultaneous requests in IDLE, data SHALL win (fixed priority).
REQ-021 A lone requester SHALL always be granted regardless of policy.

Reset
REQ-022 reset_ low SHALL immediately force state=IDLE, owner=INST, round-robin pointer=INST-last-served, independent of clock.
REQ-023 While reset_ is low, memory_request and all address_ready/data_ready outputs SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon it; a data_ready arriving after release in IDLE SHALL be ignored.

Configuration
REQ-025 With SRAM_LIKE_ARBITER_ROUND_ROBIN_EN defined: simultaneous requests SHALL go to the requester not served last; the pointer updates on each DATA completion.
REQ-026 Without SRAM_LIKE_ARBITER_ROUND_ROBIN_EN: fixed data priority per REQ-020; no pointer register is built.

Structure
REQ-027 Package sram_like_arbiter_params (include/sram_like_arbiter_params.svh) SHALL hold the state enum (IDLE/ADDR/DATA) and owner enum (INST/DATA); cpu_data_t SHALL come from cpu_core_params.
REQ-028 Grant selection (priority/round-robin, pointer input) SHALL be a combinational sub-module sram_like_arbiter_grant.

Verification
REQ-029 Inst read 0xBFC00000, address_ready same cycle, data_ready 2 cycles later with 0x3C1D0001 -> inst data_ready one pulse, read_data=0x3C1D0001, data side sees no ready.
REQ-030 Both request in IDLE (data write 0x80000010, strobe 0xF, data 0x12345678) -> memory_address=0x80000010, memory_write=1; inst waits, granted in the next IDLE after completion.
REQ-031 Inst granted, address_ready held low 3 cycles while data raises request -> memory_address stays inst's for all 3 cycles (lock).
REQ-032 ROUND_ROBIN_EN, both requesting continuously for 4 transactions -> grant order DATA, INST, DATA, INST; without macro -> DATA each time.
REQ-033 reset_ low during DATA, data_ready pulse after release -> no requester data_ready, state IDLE, memory_request=0.
REQ-034 Owner drops request in ADDR before address_ready -> returns to IDLE, no data_ready ever forwarded.
